prog_loader: RTL and testbench

Upstream stage of the toy CPU. Receives a byte stream (UART receiver output), assembles big-endian 16-bit instruction words and writes them into instruction memory through a write port. Holds the processor in reset (cpu_rst) until a complete, valid image is loaded, then releases it so execution starts at PC 0.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/prog_loader.sv | 137 +++++++++++++
 tb/tb_prog_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// loader_pkg : shared types and defaults for the program loader
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  // Must match the processor's instruction memory depth (2**7 = 128 words).
  localparam int          LOADER_ADDR_W    = 7;
  localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CNT_HI  = 3'd1,
    S_CNT_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CSUM    = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : byte-stream image loader into instruction memory; holds the
//               CPU in reset until a full image is loaded. Optional CHECKSUM_EN.
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = LOADER_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [15:0] DEPTH = 16'(1 << ADDR_W);
`ifdef CHECKSUM_EN
  localparam state_t AFTER_DATA = S_CSUM;
`else
  localparam state_t AFTER_DATA = S_DONE;
`endif

  state_t            state;
  state_t            next;
  logic [7:0]        hi;
  logic [15:0]       count;
  logic [ADDR_W:0]   idx;
  logic [15:0]       count_w;
  logic              last;
`ifdef CHECKSUM_EN
  logic [7:0]        csum;
`endif

  always_comb begin
    next    = state;
    count_w = {hi, rx_data};
    last    = ((16'(idx) + 16'd1) == count);
    case (state)
      S_IDLE:    if (rx_valid && rx_data == SYNC_BYTE) next = S_CNT_HI;
      S_CNT_HI:  if (rx_valid) next = S_CNT_LO;
      S_CNT_LO:
        if (rx_valid) begin
          if (count_w == 16'd0)      next = AFTER_DATA;
          else if (count_w > DEPTH)  next = S_ERR;
          else                       next = S_DATA_HI;
        end
      S_DATA_HI: if (rx_valid) next = S_DATA_LO;
      S_DATA_LO: if (rx_valid) next = last ? AFTER_DATA : S_DATA_HI;
`ifdef CHECKSUM_EN
      S_CSUM:    if (rx_valid) next = (rx_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE,
      S_ERR:     if (load_req) next = S_IDLE;
      default:   next = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hi         <= 8'd0;
      count      <= 16'd0;
      idx        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 16'd0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      state   <= next;
      imem_we <= 1'b0;
      // Status flags follow the next state so they line up with it exactly.
      cpu_rst <= (next != S_DONE);
      done    <= (next == S_DONE);
      error   <= (next == S_ERR);
      busy    <= (next inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CSUM});
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
`ifdef CHECKSUM_EN
            if (rx_data == SYNC_BYTE) csum <= 8'd0;
`endif
          end
          S_CNT_HI: begin
            hi <= rx_data;
`ifdef CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
          S_CNT_LO: begin
            count <= count_w;
            idx   <= '0;
`ifdef CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
          S_DATA_HI: begin
            hi <= rx_data;
`ifdef CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
          S_DATA_LO: begin
            imem_we    <= 1'b1;
            imem_addr  <= idx[ADDR_W-1:0];
            imem_wdata <= {hi, rx_data};
            idx        <= idx + (ADDR_W+1)'(1);
`ifdef CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : table-driven frames plus a write scoreboard for prog_loader
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        load_req = 1'b0;
  logic        imem_we;
  logic [6:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_rst, busy, done, error;

  prog_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] count;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          garbage;
    bit          bad_csum;
    bit          exp_done;
    bit          exp_error;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [22:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic [6:0]  last_wr_addr = 7'd0;
  bit          csum_on;
  vec_t        tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the oldest expected write and follow
  // the low-byte strobe by exactly one cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {25'd0, imem_addr}, {25'd0, e[22:16]});
        check("wr_data", {16'd0, imem_wdata}, {16'd0, e[15:0]});
        check("wr_latency", {31'd0, prev_valid}, 32'd1);
      end
      last_wr_addr = imem_addr;
    end
    prev_valid = rx_valid;
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic pulse_load_req();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_of(input int i, input logic [15:0] w0, input logic [15:0] w1);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return 16'(i * 16'h0102 + 16'h0F00);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    {31'd0, imem_we},    32'd0);
    check({tag, "_addr"},  {25'd0, imem_addr},  32'd0);
    check({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
    check({tag, "_cpurst"},{31'd0, cpu_rst},    32'd1);
    check({tag, "_busy"},  {31'd0, busy},       32'd0);
    check({tag, "_done"},  {31'd0, done},       32'd0);
    check({tag, "_error"}, {31'd0, error},      32'd0);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0]  cs;
    logic [15:0] w;
    bit          ovf;
    int          n;
    if (v.garbage) begin
      send(8'h00); send(8'hFF); send(8'h5A);
    end
    send(8'hA5);
    send(v.count[15:8]);
    send(v.count[7:0]);
    cs  = v.count[15:8] ^ v.count[7:0];
    ovf = (v.count > 16'd128);
    n   = ovf ? 2 : int'(v.count);
    for (int i = 0; i < n; i++) begin
      w = word_of(i, v.w0, v.w1);
      send(w[15:8]);
      cs ^= w[15:8];
      if (!ovf) exp_q.push_back({7'(i), w});
      send(w[7:0]);
      cs ^= w[7:0];
    end
    if (csum_on && !ovf) send(v.bad_csum ? (cs ^ 8'h01) : cs);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done"},   {31'd0, done},    {31'd0, v.exp_done});
    check({tag, "_error"},  {31'd0, error},   {31'd0, v.exp_error});
    check({tag, "_cpurst"}, {31'd0, cpu_rst}, {31'd0, !v.exp_done});
    check({tag, "_busy"},   {31'd0, busy},    32'd0);
    check({tag, "_pending"}, exp_q.size(),    32'd0);
    exp_q.delete();
    if (v.count == 16'd128)
      check({tag, "_last_addr"}, {25'd0, last_wr_addr}, 32'h7F);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CHECKSUM_EN
    csum_on = 1'b1;
`else
    csum_on = 1'b0;
`endif
    //          count     w0        w1        garb  badcs done         err
    tbl[0] = '{16'h0002, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b1,        1'b0};
    tbl[1] = '{16'h0002, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1,        1'b0};
    tbl[2] = '{16'h0081, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0,        1'b1};
    tbl[3] = '{16'h0002, 16'h1234, 16'hABCD, 1'b0, 1'b1, !csum_on,    csum_on};
    tbl[4] = '{16'h0080, 16'hBEEF, 16'hCAFE, 1'b0, 1'b0, 1'b1,        1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1,        1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      if (done || error) begin
        pulse_load_req();
        check($sformatf("rearm%0d_done", k),   {31'd0, done},    32'd0);
        check($sformatf("rearm%0d_error", k),  {31'd0, error},   32'd0);
        check($sformatf("rearm%0d_cpurst", k), {31'd0, cpu_rst}, 32'd1);
      end
      run_frame(tbl[k], $sformatf("row%0d", k));
    end

    // load_req mid-frame is ignored, then reset between the bytes of word 1.
    pulse_load_req();
    send(8'hA5);
    pulse_load_req();
    check("midreq_busy", {31'd0, busy}, 32'd1);
    send(8'h00); send(8'h02);
    exp_q.push_back({7'd0, 16'h1234});
    send(8'h12); send(8'h34); send(8'hAB);
    check("midrst_pending", exp_q.size(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(tbl[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
